// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver.
//   rx_state_e    - receive FSM states
//   ENT_*         - bit positions inside an 11-bit FIFO entry {brk, fe, pe, data}
//   rx_entry_t    - packed view of the same entry
//   DB_*          - data_bits encoding (number of data bits per character)
//   last_bit_idx  - index of the final data bit for a data_bits code
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_e;

  localparam int ENT_W        = 11;
  localparam int ENT_DATA_LSB = 0;
  localparam int ENT_PE       = 8;
  localparam int ENT_FE       = 9;
  localparam int ENT_BRK      = 10;

  typedef struct packed {
    logic       brk;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
    case (db)
      DB_5:    return 3'd4;
      DB_6:    return 3'd5;
      DB_7:    return 3'd6;
      DB_8:    return 3'd7;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk_i, rst_n_i  clock, synchronous active-low reset (clears pointers/count)
//   wr_en_i/wr_data_i  push; accepted when not full, or when full with a same-cycle pop
//   rd_en_i            pop head; ignored when empty
//   rd_data_o          current head (valid whenever empty_o is 0)
//   count_o            entries held; empty_o / full_o derived from it
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr, do_rd;

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign do_rd   = rd_en_i && !empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_wr   = wr_en_i && (!full_o || do_rd);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr];
  assign count_o   = count;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with runtime frame format, error-flag
// FIFO and character timeout.
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   baud_tick_i         one-cycle pulse, OSR per bit-time
//   rx_i                asynchronous serial input, idle high
//   data_bits_i, parity_en_i, even_parity_i, stop2_i   frame format (latched at start)
//   rd_en_i, ovr_clr_i  pop head entry / clear sticky overrun
//   rx_data_o, parity_err_o, frame_err_o, break_o       head entry, 0 when empty
//   rx_not_empty_o, rx_full_o, level_o                  FIFO status
//   rx_overrun_o        sticky dropped-character flag
//   timeout_o           FIFO non-empty and line idle for TIMEOUT_BITS bit-times
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OSR          = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMEOUT_BITS = 40,
  parameter int LW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          baud_tick_i,
  input  logic          rx_i,
  input  logic [1:0]    data_bits_i,
  input  logic          parity_en_i,
  input  logic          even_parity_i,
  input  logic          stop2_i,
  input  logic          rd_en_i,
  input  logic          ovr_clr_i,
  output logic [7:0]    rx_data_o,
  output logic          parity_err_o,
  output logic          frame_err_o,
  output logic          break_o,
  output logic          rx_not_empty_o,
  output logic          rx_full_o,
  output logic [LW-1:0] level_o,
  output logic          rx_overrun_o,
  output logic          timeout_o
);

  localparam int TW     = $clog2(OSR);
  localparam int TO_LIM = TIMEOUT_BITS * OSR;
  localparam int TOW    = $clog2(TO_LIM + 1);
  localparam logic [TW-1:0] S0    = TW'(OSR/2 - 1);
  localparam logic [TW-1:0] S1    = TW'(OSR/2);
  localparam logic [TW-1:0] S2    = TW'(OSR/2 + 1);
  localparam logic [TW-1:0] TLAST = TW'(OSR - 1);

  // ---------------- synchroniser ----------------
  logic rx_s1, rxs;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rxs   <= rx_s1;
    end
  end

  // ---------------- receive FSM ----------------
  rx_state_e     state, state_n;
  logic [TW-1:0] tick_cnt, tick_n, tick_nxt;
  logic [2:0]    bit_cnt, bit_n, last_q, last_n;
  logic [7:0]    data_q, data_n;
  logic [1:0]    ones_q, ones_n, ones_sum;
  logic          par_q, par_n, pe_q, pe_n;
  logic          pen_q, pen_n, even_q, even_n, stop2_q, stop2_n;
  logic          bit_end, is_sample, is_vote, vote, exp_par, brk;
  logic          push;
  rx_entry_t     push_ent;

  // tick_cnt holds the index of the latest tick within the current bit.
  assign bit_end   = (tick_cnt == TLAST);
  assign tick_nxt  = bit_end ? '0 : tick_cnt + 1'b1;
  assign is_sample = (tick_nxt == S0) || (tick_nxt == S1);
  assign is_vote   = (tick_nxt == S2);
  assign ones_sum  = ones_q + {1'b0, rxs};
  assign vote      = ones_sum[1];  // two or three of the three samples high
  assign exp_par   = even_q ? ^data_q : ~(^data_q);
  // Break: everything in the frame, including the stop bit, read as 0.
  assign brk       = (data_q == '0) && (!pen_q || !par_q) && !vote;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      last_q   <= '0;
      data_q   <= '0;
      ones_q   <= '0;
      par_q    <= 1'b0;
      pe_q     <= 1'b0;
      pen_q    <= 1'b0;
      even_q   <= 1'b0;
      stop2_q  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      last_q   <= last_n;
      data_q   <= data_n;
      ones_q   <= ones_n;
      par_q    <= par_n;
      pe_q     <= pe_n;
      pen_q    <= pen_n;
      even_q   <= even_n;
      stop2_q  <= stop2_n;
    end
  end

  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    last_n   = last_q;
    data_n   = data_q;
    ones_n   = ones_q;
    par_n    = par_q;
    pe_n     = pe_q;
    pen_n    = pen_q;
    even_n   = even_q;
    stop2_n  = stop2_q;
    push     = 1'b0;
    push_ent = '0;
    if (state == ST_IDLE) begin
      if (baud_tick_i && !rxs) begin
        state_n = ST_START;
        tick_n  = '0;
        bit_n   = '0;
        data_n  = '0;
        ones_n  = '0;
        par_n   = 1'b0;
        pe_n    = 1'b0;
        last_n  = last_bit_idx(data_bits_i);
        pen_n   = parity_en_i;
        even_n  = even_parity_i;
        stop2_n = stop2_i;
      end
    end else if (state == ST_BRK_WAIT) begin
      if (rxs) state_n = ST_IDLE;
    end else if (baud_tick_i) begin
      tick_n = tick_nxt;
      if (is_sample)    ones_n = ones_sum;
      else if (is_vote) ones_n = '0;
      case (state)
        ST_START: begin
          if (is_vote && vote) state_n = ST_IDLE;  // false start
          else if (bit_end)    state_n = ST_DATA;
        end
        ST_DATA: begin
          if (is_vote) data_n[bit_cnt] = vote;
          if (bit_end) begin
            if (bit_cnt == last_q) state_n = pen_q ? ST_PARITY : ST_STOP1;
            else                   bit_n   = bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          if (is_vote) begin
            par_n = vote;
            pe_n  = vote ^ exp_par;
          end
          if (bit_end) state_n = ST_STOP1;
        end
        ST_STOP1: begin
          // Leave at the centre vote so the rest of the stop bit is free to
          // resynchronise on the next start edge.
          if (is_vote) begin
            push = 1'b1;
            if (brk) begin
              push_ent.brk = 1'b1;
              push_ent.fe  = 1'b1;
              state_n      = ST_BRK_WAIT;
            end else begin
              push_ent.fe   = !vote;
              push_ent.pe   = pe_q;
              push_ent.data = data_q;
              state_n       = stop2_q ? ST_STOP2 : ST_IDLE;
              tick_n        = '0;
            end
          end
        end
        ST_STOP2: begin
          if (bit_end) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // ---------------- FIFO ----------------
  logic [ENT_W-1:0] head;
  logic [LW-1:0]    fifo_cnt;
  logic             empty, full, pop;

  uart_sync_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (push),
    .wr_data_i (push_ent),
    .rd_en_i   (rd_en_i),
    .rd_data_o (head),
    .count_o   (fifo_cnt),
    .empty_o   (empty),
    .full_o    (full)
  );

  assign pop = rd_en_i && !empty;

  // ---------------- overrun / timeout ----------------
  logic           ovr_q;
  logic [TOW-1:0] to_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovr_q <= 1'b0;
    end else if (push && full && !pop) begin
      ovr_q <= 1'b1;
    end else if (ovr_clr_i) begin
      ovr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      to_cnt <= '0;
    end else if (empty || push || pop) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE && baud_tick_i && to_cnt != TOW'(TO_LIM)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign rx_data_o      = empty ? 8'h00 : head[ENT_DATA_LSB +: 8];
  assign parity_err_o   = !empty && head[ENT_PE];
  assign frame_err_o    = !empty && head[ENT_FE];
  assign break_o        = !empty && head[ENT_BRK];
  assign rx_not_empty_o = !empty;
  assign rx_full_o      = full;
  assign level_o        = fifo_cnt;
  assign rx_overrun_o   = ovr_q;
  assign timeout_o      = (to_cnt == TOW'(TO_LIM));

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os (OSR=16, FIFO_DEPTH=4). Characters are driven bit by
// bit against the tick stream; expected entries go into a queue when a frame
// is sent and are compared against the FIFO head when popped.
module tb_uart_rx_os;

  localparam int OSR = 16;
  localparam int FD  = 4;
  localparam int LW  = $clog2(FD + 1);

  logic          clk, rst_n, baud_tick, rx;
  logic [1:0]    data_bits;
  logic          parity_en, even_parity, stop2, rd_en, ovr_clr;
  logic [7:0]    rx_data;
  logic          parity_err, frame_err, brk_o, not_empty, full, overrun, timeout;
  logic [LW-1:0] level;
  logic [10:0]   head;

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] q[$];

  uart_rx_os #(.OSR(OSR), .FIFO_DEPTH(FD), .TIMEOUT_BITS(40)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .baud_tick_i    (baud_tick),
    .rx_i           (rx),
    .data_bits_i    (data_bits),
    .parity_en_i    (parity_en),
    .even_parity_i  (even_parity),
    .stop2_i        (stop2),
    .rd_en_i        (rd_en),
    .ovr_clr_i      (ovr_clr),
    .rx_data_o      (rx_data),
    .parity_err_o   (parity_err),
    .frame_err_o    (frame_err),
    .break_o        (brk_o),
    .rx_not_empty_o (not_empty),
    .rx_full_o      (full),
    .level_o        (level),
    .rx_overrun_o   (overrun),
    .timeout_o      (timeout)
  );

  assign head = {brk_o, frame_err, parity_err, rx_data};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every 4 clocks, changed just after posedge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns on the negedge just before the n-th following tick edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(negedge clk); while (baud_tick !== 1'b1);
    end
  endtask

  task automatic pop_check(input string name);
    int w;
    logic [10:0] e;
    w = 0;
    while (!not_empty && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_ready"}, 32'(not_empty), 32'd1);
    if (q.size() == 0) begin
      chk({name, "_queue"}, 32'(q.size()), 32'd1);
    end else begin
      e = q.pop_front();
      chk(name, 32'(head), 32'(e));
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Format inputs are inverted once the frame is under way; the frame must
  // still decode with the format present at the start edge.
  task automatic send(input logic [7:0] d, input int nb, input bit pen, input bit ev,
                      input bit st2, input bit bad_par, input bit stop_low,
                      input bit stop2_low, input bit pop_at_push);
    logic par;
    par = 1'b0;
    data_bits = 2'(nb - 5); parity_en = pen; even_parity = ev; stop2 = st2;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(16);
    data_bits = ~data_bits; parity_en = ~pen; even_parity = ~ev; stop2 = ~st2;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) wait_ticks(16);
      rx = d[i];
      par ^= d[i];
    end
    if (pen) begin
      wait_ticks(16);
      rx = (ev ? par : ~par) ^ bad_par;
    end
    wait_ticks(16);
    rx = ~stop_low;
    if (pop_at_push) begin
      // Centre vote of the stop bit lands on the 10th tick after it begins.
      wait_ticks(10);
      chk("pop_at_push_head", 32'(head), 32'(q.pop_front()));
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      wait_ticks(6);
    end else begin
      wait_ticks(16);
    end
    if (st2) begin
      rx = ~stop2_low;
      wait_ticks(16);
    end
    rx = 1'b1;
    data_bits = 2'(nb - 5); parity_en = pen; even_parity = ev; stop2 = st2;
    wait_ticks(20);
  endtask

  typedef struct packed {
    logic [7:0]  d;
    logic [3:0]  nb;
    logic        pen, ev, st2, bad_par, stop_low, stop2_low;
    logic [10:0] exp;   // {brk, fe, pe, data}
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {3'b000, 8'hA5}};
    vecs[1] = '{8'h55, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {3'b001, 8'h55}};
    vecs[2] = '{8'h1F, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {3'b000, 8'h1F}};
    vecs[3] = '{8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {3'b010, 8'h3C}};
    vecs[4] = '{8'h2A, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {3'b000, 8'h2A}};
    vecs[5] = '{8'h00, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {3'b000, 8'h00}};
    vecs[6] = '{8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {3'b110, 8'h00}};
    vecs[7] = '{8'hFF, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {3'b000, 8'h7F}};
    vecs[8] = '{8'h81, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {3'b001, 8'h81}};

    rst_n = 1'b0; rx = 1'b1; data_bits = 2'b11; parity_en = 1'b0;
    even_parity = 1'b0; stop2 = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({rx_data, parity_err, frame_err, brk_o, not_empty, full,
                              level, overrun, timeout}), 32'd0);
    rst_n = 1'b1;
    wait_ticks(4);

    // ---- table-driven frames ----
    for (int i = 0; i < 9; i++) begin
      q.push_back(vecs[i].exp);
      send(vecs[i].d, int'(vecs[i].nb), vecs[i].pen, vecs[i].ev, vecs[i].st2,
           vecs[i].bad_par, vecs[i].stop_low, vecs[i].stop2_low, 1'b0);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'd1);
      pop_check($sformatf("vec%0d_entry", i));
    end
    chk("empty_after_pop", 32'({not_empty, rx_data}), 32'd0);

    // ---- glitch on idle line ----
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    chk("glitch_level", 32'(level), 32'd0);

    // ---- line low for two frames: exactly one break entry ----
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(320);
    rx = 1'b1;
    wait_ticks(40);
    q.push_back({3'b110, 8'h00});
    chk("long_break_level", 32'(level), 32'd1);
    pop_check("long_break_entry");

    // ---- fill past depth ----
    for (int k = 0; k < 5; k++) begin
      if (k < 4) q.push_back({3'b000, 8'(8'h11 + k)});
      send(8'(8'h11 + k), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("full_level", 32'(level), 32'(FD));
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("overrun_clr", 32'(overrun), 32'd0);
    q.push_back({3'b000, 8'h16});
    send(8'h16, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("push_pop_full_no_ovr", 32'(overrun), 32'd0);
    chk("push_pop_full_level", 32'(level), 32'(FD));
    for (int k = 0; k < 4; k++) pop_check($sformatf("drain%0d", k));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("pop_empty_ignored", 32'({not_empty, level}), 32'd0);

    // ---- character timeout ----
    q.push_back({3'b000, 8'h42});
    send(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("timeout_early", 32'(timeout), 32'd0);
    wait_ticks(590);
    chk("timeout_not_yet", 32'(timeout), 32'd0);
    begin
      int w;
      w = 0;
      while (timeout !== 1'b1 && w < 80) begin
        wait_ticks(1);
        w++;
      end
    end
    @(negedge clk);
    chk("timeout_set", 32'(timeout), 32'd1);
    pop_check("timeout_entry");
    chk("timeout_clr_on_pop", 32'(timeout), 32'd0);

    // ---- reset in the middle of DATA ----
    q.push_back({3'b000, 8'h99});
    send(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(20);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_mid_frame", 32'({rx_data, parity_err, frame_err, brk_o, not_empty, full,
                                level, overrun, timeout}), 32'd0);
    rx = 1'b1;
    rst_n = 1'b1;
    q.delete();
    wait_ticks(200);
    chk("no_push_after_reset", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
